// File: rtl/motion_seq.sv
// Drive-servo command sequencer: a one-deep command queue feeding a frame-aligned
// PWM generator for the left and right servos. Width changes take effect only at frame boundaries.
module motion_seq #(
  parameter int FRAME_CYC   = 1000000,
  parameter int NEUTRAL_CYC = 75000,
  parameter int SPD_CYC     = 25000,
  parameter int CNT_W       = 20,
  parameter int DUR_W       = 8
) (
  input  logic             clk0,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [DUR_W-1:0] cmd_dur,
  input  logic             abort,
  output logic             pwm_l,
  output logic             pwm_r,
  output logic             frame_tick,
  output logic             busy,
  output logic             done,
  output logic             err_op,
  output logic             fsm_state
);

  // Handshake: a command transfers on a rising clk0 edge where cmd_valid && cmd_ready.
  // cmd_ready is high only while the queue is empty and abort is low.

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_CYC - 1);
  localparam logic [CNT_W-1:0] W_N      = CNT_W'(NEUTRAL_CYC);
  localparam logic [CNT_W-1:0] W_HI     = CNT_W'(NEUTRAL_CYC + SPD_CYC);
  localparam logic [CNT_W-1:0] W_LO     = CNT_W'(NEUTRAL_CYC - SPD_CYC);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [CNT_W-1:0]   act_w_l, act_w_r, w_l_nxt, w_r_nxt;
  logic [CNT_W-1:0]   op_w_l, op_w_r;
  logic [DUR_W-1:0]   rem, rem_nxt;
  logic               q_valid;
  logic [2:0]         q_op;
  logic [DUR_W-1:0]   q_dur;
  logic               accept, load, q_clr;

  assign cnt_nxt   = (cnt == LAST_CNT) ? '0 : cnt + CNT_W'(1);
  assign cmd_ready = !q_valid && !abort;
  assign accept    = cmd_valid && cmd_ready;
  assign err_op    = accept && (cmd_op > 3'd4);
  assign busy      = (state == RUN) || q_valid;
  assign fsm_state = state;

  // Illegal ops fall through to STOP widths.
  always_comb begin
    op_w_l = W_N;
    op_w_r = W_N;
    case (q_op)
      3'd1:    begin op_w_l = W_HI; op_w_r = W_LO; end
      3'd2:    begin op_w_l = W_LO; op_w_r = W_HI; end
      3'd3:    begin op_w_l = W_LO; op_w_r = W_LO; end
      3'd4:    begin op_w_l = W_HI; op_w_r = W_HI; end
      default: begin op_w_l = W_N;  op_w_r = W_N;  end
    endcase
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    w_l_nxt   = act_w_l;
    w_r_nxt   = act_w_r;
    load      = 1'b0;
    q_clr     = 1'b0;
    done      = 1'b0;
    if (abort) begin
      // The running pulse keeps its width until the frame ends.
      state_nxt = IDLE;
      if (frame_tick) begin
        w_l_nxt = W_N;
        w_r_nxt = W_N;
      end
    end else if (frame_tick) begin
      case (state)
        IDLE: begin
          if (q_valid) begin
            load = 1'b1;
          end else begin
            w_l_nxt = W_N;
            w_r_nxt = W_N;
          end
        end
        RUN: begin
          if (rem > DUR_W'(1)) begin
            rem_nxt = rem - DUR_W'(1);
          end else begin
            done = 1'b1;
            if (q_valid) begin
              load = 1'b1;
            end else begin
              w_l_nxt   = W_N;
              w_r_nxt   = W_N;
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
      if (load) begin
        q_clr = 1'b1;
        if (q_dur == '0) begin
          done      = 1'b1;
          w_l_nxt   = W_N;
          w_r_nxt   = W_N;
          state_nxt = IDLE;
        end else begin
          w_l_nxt   = op_w_l;
          w_r_nxt   = op_w_r;
          rem_nxt   = q_dur;
          state_nxt = RUN;
        end
      end
    end
  end

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      frame_tick <= 1'b0;
      pwm_l      <= 1'b0;
      pwm_r      <= 1'b0;
      act_w_l    <= W_N;
      act_w_r    <= W_N;
      rem        <= '0;
      q_valid    <= 1'b0;
      q_op       <= '0;
      q_dur      <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      frame_tick <= (cnt_nxt == LAST_CNT);
      pwm_l      <= (cnt < act_w_l);
      pwm_r      <= (cnt < act_w_r);
      act_w_l    <= w_l_nxt;
      act_w_r    <= w_r_nxt;
      rem        <= rem_nxt;
      // Accept and load never coincide: accept needs an empty queue, load a full one.
      if (abort) begin
        q_valid <= 1'b0;
      end else if (accept) begin
        q_valid <= 1'b1;
        q_op    <= cmd_op;
        q_dur   <= cmd_dur;
      end else if (q_clr) begin
        q_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_motion_seq.sv
// Directed bench for motion_seq with a 100-cycle frame, neutral 15 and speed offset 5.
// Pulse widths are measured per frame by counting high cycles between frame ticks.
module tb_motion_seq;

  logic       clk0 = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [3:0] cmd_dur = '0;
  logic       abort = 1'b0;
  logic       pwm_l, pwm_r, frame_tick, busy, done, err_op, fsm_state;

  int tests = 0;
  int fails = 0;
  int acc_l = 0, acc_r = 0, acc_d = 0;
  int fl = 0, fr = 0, fd = 0;
  int cyc = 0, last_tick = 0, period = 0;
  bit new_frame = 1'b0;

  motion_seq #(
    .FRAME_CYC(100), .NEUTRAL_CYC(15), .SPD_CYC(5), .CNT_W(7), .DUR_W(4)
  ) dut (
    .clk0(clk0), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dur(cmd_dur), .abort(abort), .pwm_l(pwm_l), .pwm_r(pwm_r),
    .frame_tick(frame_tick), .busy(busy), .done(done), .err_op(err_op),
    .fsm_state(fsm_state)
  );

  always #5 clk0 = ~clk0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_acc();
    acc_l = 0; acc_r = 0; acc_d = 0;
  endtask

  task automatic step();
    @(negedge clk0);
    cyc++;
    if (pwm_l === 1'b1) acc_l++;
    if (pwm_r === 1'b1) acc_r++;
    if (done === 1'b1) acc_d++;
    new_frame = 1'b0;
    if (frame_tick === 1'b1) begin
      fl = acc_l; fr = acc_r; fd = acc_d;
      period = cyc - last_tick;
      last_tick = cyc;
      clear_acc();
      new_frame = 1'b1;
    end
  endtask

  task automatic next_frame();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!new_frame && n < 250);
    if (!new_frame) check("tick_timeout", 0, 1);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic frame_chk(input string tag, input int el, input int er, input int ed);
    next_frame();
    check({tag, "_l"}, fl, el);
    check({tag, "_r"}, fr, er);
    check({tag, "_done"}, fd, ed);
  endtask

  task automatic send(input logic [2:0] op, input logic [3:0] dur, input logic exp_err);
    cmd_valid = 1'b1; cmd_op = op; cmd_dur = dur;
    #1;
    check("send_ready", cmd_ready, 1);
    check("send_err", err_op, exp_err);
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    @(negedge clk0);
    @(negedge clk0);
    check("rst_pwm_l", pwm_l, 0);
    check("rst_pwm_r", pwm_r, 0);
    check("rst_tick", frame_tick, 0);
    check("rst_done", done, 0);
    check("rst_err", err_op, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cmd_ready, 1);
    rst_n = 1'b1;
    clear_acc();

    // Idle frames are neutral, 100 cycles apart
    frame_chk("idle0", 15, 15, 0);
    frame_chk("idle1", 15, 15, 0);
    check("idle_period", period, 100);
    check("idle_busy", busy, 0);

    // FWD dur 3 accepted mid-frame
    steps(10);
    send(3'd1, 4'd3, 1'b0);
    check("fwd_busy_q", busy, 1);
    frame_chk("fwd_cur", 15, 15, 0);
    frame_chk("fwd_f1", 20, 10, 0);
    frame_chk("fwd_f2", 20, 10, 0);
    frame_chk("fwd_f3", 20, 10, 1);
    check("fwd_busy_done", busy, 1);
    step();
    check("fwd_busy_fall", busy, 0);
    frame_chk("fwd_after", 15, 15, 0);

    // BACK dur 2, then SPIN_R dur 1 queued behind it
    steps(5);
    send(3'd2, 4'd2, 1'b0);
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_dur = 4'd1;
    #1;
    check("q_full_ready", cmd_ready, 0);
    frame_chk("back_cur", 15, 15, 0);
    check("q_tick_ready", cmd_ready, 0);
    step();
    check("q_free_ready", cmd_ready, 1);
    check("spin_err", err_op, 0);
    step();
    cmd_valid = 1'b0;
    frame_chk("back_f1", 10, 20, 0);
    frame_chk("back_f2", 10, 20, 1);
    frame_chk("spinr_f1", 20, 20, 1);
    frame_chk("chain_after", 15, 15, 0);

    // Abort in the second frame of FWD dur 5; cmd in abort cycle is dropped
    steps(5);
    send(3'd1, 4'd5, 1'b0);
    frame_chk("ab_cur", 15, 15, 0);
    frame_chk("ab_f1", 20, 10, 0);
    steps(30);
    abort = 1'b1; cmd_valid = 1'b1; cmd_op = 3'd3; cmd_dur = 4'd1;
    #1;
    check("ab_ready", cmd_ready, 0);
    step();
    abort = 1'b0; cmd_valid = 1'b0;
    check("ab_busy", busy, 0);
    frame_chk("ab_f2", 20, 10, 0);
    frame_chk("ab_after", 15, 15, 0);
    check("ab_busy_idle", busy, 0);

    // Illegal op 6, dur 2
    steps(5);
    send(3'd6, 4'd2, 1'b1);
    frame_chk("ill_cur", 15, 15, 0);
    frame_chk("ill_f1", 15, 15, 0);
    check("ill_busy", busy, 1);
    frame_chk("ill_f2", 15, 15, 1);
    frame_chk("ill_after", 15, 15, 0);

    // dur 0: done at the load tick, no width change
    steps(5);
    send(3'd1, 4'd0, 1'b0);
    frame_chk("dur0_load", 15, 15, 1);
    frame_chk("dur0_after", 15, 15, 0);
    check("dur0_busy", busy, 0);

    // Reset at cnt 7 of a FWD frame
    steps(5);
    send(3'd1, 4'd4, 1'b0);
    frame_chk("rr_cur", 15, 15, 0);
    steps(8);
    check("rr_pre_l", pwm_l, 1);
    check("rr_pre_r", pwm_r, 1);
    rst_n = 1'b0;
    #1;
    check("rr_pwm_l", pwm_l, 0);
    check("rr_pwm_r", pwm_r, 0);
    check("rr_busy", busy, 0);
    step();
    rst_n = 1'b1;
    clear_acc();
    frame_chk("rr_idle0", 15, 15, 0);
    frame_chk("rr_idle1", 15, 15, 0);
    check("rr_busy_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
